// File: rtl/spi_slave_pkg.sv
// Shared types and frame-field constants for the SPI slave memory target.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA
  } state_e;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 32;
  localparam int CMD_WR_BIT = 7;
  localparam int STRB_LSB   = 0;
  localparam int STRB_W     = 4;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronisers for SPI pins plus edge detection on SCLK and CS_N.
module spi_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_rise_o,
  output logic cs_fall_o,
  output logic mosi_o
);

  logic [2:0] sclk_q;
  logic [2:0] cs_n_q;
  logic [1:0] mosi_q;

  // Reset to 0 so a CS held low across reset never looks like a fresh falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q <= '0;
      cs_n_q <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      cs_n_q <= {cs_n_q[1:0], cs_n_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];
  assign cs_rise_o   = cs_n_q[1] & ~cs_n_q[2];
  assign cs_fall_o   = ~cs_n_q[1] & cs_n_q[2];
  assign mosi_o      = mosi_q[1];

endmodule

// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave decoding CMD/ADDR/DATA frames into a byte-strobed word memory
// with auto-incrementing burst reads and writes.
module spi_slave_mem
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_LSB   = 2
) (
  input  logic spi_clk,
  input  logic spi_rst,
  input  logic spi_cs_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic frame_done,
  output logic frame_err
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int SH_W   = ADDR_WIDTH;
  localparam int CNT_W  = $clog2(SH_W);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int HI_BIT = ADDR_LSB + IDX_W;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

  spi_edge_sync u_sync (
    .clk_i       (spi_clk),
    .rst_i       (spi_rst),
    .sclk_i      (spi_sclk),
    .cs_n_i      (spi_cs_n),
    .mosi_i      (spi_mosi),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_rise_o   (cs_rise),
    .cs_fall_o   (cs_fall),
    .mosi_o      (mosi_s)
  );

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]         rx_q, rx_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic                    wr_q, wr_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    oor_q, oor_d;
  logic                    word_seen_q, word_seen_d;
  logic                    load_q, load_d;
  logic                    miso_q, miso_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [SH_W-1:0]         rx_shift;
  logic                    mem_we;
  logic [NBYTES-1:0]       byte_we;
  logic [DATA_WIDTH-1:0]   wdata;

  assign rx_shift = {rx_q[SH_W-2:0], mosi_s};
  assign wdata    = rx_shift[DATA_WIDTH-1:0];

  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      wr_q        <= 1'b0;
      strb_q      <= '0;
      idx_q       <= '0;
      oor_q       <= 1'b0;
      word_seen_q <= 1'b0;
      load_q      <= 1'b0;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      wr_q        <= wr_d;
      strb_q      <= strb_d;
      idx_q       <= idx_d;
      oor_q       <= oor_d;
      word_seen_q <= word_seen_d;
      load_q      <= load_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    wr_d        = wr_q;
    strb_d      = strb_q;
    idx_d       = idx_q;
    oor_d       = oor_q;
    word_seen_d = word_seen_q;
    load_d      = 1'b0;
    miso_d      = miso_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;

    // Preload happens one cycle after the word boundary, well before the next SCLK fall.
    if (load_q) begin
      tx_d = oor_q ? '0 : mem_q[idx_q];
    end

    if (state_q == ST_IDLE) begin
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      if (cs_fall) begin
        state_d     = ST_CMD;
        word_seen_d = 1'b0;
        oor_d       = 1'b0;
      end
    end else if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      if (state_q == ST_CMD || state_q == ST_ADDR || bit_cnt_q != '0 ||
          !word_seen_q || oor_q) begin
        err_d = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_CMD: if (sclk_rise) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
            wr_d      = rx_shift[CMD_WR_BIT];
            strb_d    = rx_shift[STRB_LSB +: STRB_W];
            bit_cnt_d = '0;
            state_d   = ST_ADDR;
          end
        end
        ST_ADDR: if (sclk_rise) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            idx_d     = rx_shift[ADDR_LSB +: IDX_W];
            oor_d     = |(rx_shift >> HI_BIT);
            bit_cnt_d = '0;
            if (wr_q) begin
              state_d = ST_WDATA;
            end else begin
              state_d = ST_RDATA;
              load_d  = 1'b1;
            end
          end
        end
        ST_WDATA: if (sclk_rise) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            mem_we      = !oor_q;
            idx_d       = idx_q + IDX_W'(1);
            word_seen_d = 1'b1;
            bit_cnt_d   = '0;
          end
        end
        ST_RDATA: begin
          if (sclk_fall) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
          // Word progress follows the master's sampling edges, not our shift edges.
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              idx_d       = idx_q + IDX_W'(1);
              word_seen_d = 1'b1;
              load_d      = 1'b1;
              bit_cnt_d   = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign byte_we[gi] = mem_we & strb_q[gi];
  end

  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int b = 0; b < NBYTES; b++) begin
        if (byte_we[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign spi_miso   = miso_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Self-checking bench for spi_slave_mem: bit-banged SPI master, word model and read scoreboard.
module tb_spi_slave_mem;

  localparam int HALF = 6;

  logic spi_clk = 1'b0;
  logic spi_rst;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic frame_done;
  logic frame_err;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [31:0] model_mem [256];
  logic [31:0] wr_words [8];
  logic [31:0] exp_q [$];

  spi_slave_mem dut (
    .spi_clk    (spi_clk),
    .spi_rst    (spi_rst),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 spi_clk = ~spi_clk;

  always @(negedge spi_clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge spi_clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input logic [31:0] addr, input int nbits,
                          input int rst_bit, input logic exp_done, input logic exp_err);
    logic [31:0] rd_sh;
    logic [31:0] exp_w;
    int d0, e0, off;
    bit dead;
    d0 = done_cnt;
    e0 = err_cnt;
    dead = 0;
    rd_sh = '0;
    @(negedge spi_clk);
    spi_cs_n = 1'b0;
    idle(HALF);
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_bit) begin
        spi_rst = 1'b1;
        idle(2);
        check("rst_miso", 32'(spi_miso), 32'h0);
        spi_rst = 1'b0;
        dead = 1;
        exp_q.delete();
        model_clear();
      end
      off = b - 40;
      if (b < 8) spi_mosi = cmd[7-b];
      else if (b < 40) spi_mosi = addr[39-b];
      else if (cmd[7]) spi_mosi = wr_words[off/32][31-(off%32)];
      else spi_mosi = 1'b0;
      idle(HALF);
      if (b >= 40 && !cmd[7]) begin
        rd_sh = {rd_sh[30:0], spi_miso};
        if (off % 32 == 31 && !dead) begin
          check("rd_pending", 32'(exp_q.size() != 0), 32'h1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check("rd_data", rd_sh, exp_w);
          end
        end
      end
      spi_sclk = 1'b1;
      idle(HALF);
      spi_sclk = 1'b0;
    end
    idle(HALF);
    spi_cs_n = 1'b1;
    idle(12);
    check("frame_done", 32'(done_cnt - d0), 32'(exp_done));
    check("frame_err", 32'(err_cnt - e0), 32'(exp_err));
    $display("txn cmd=%h addr=%h bits=%0d done=%0d err=%0d", cmd, addr, nbits,
             done_cnt - d0, err_cnt - e0);
  endtask

  task automatic wr_frame(input logic [31:0] addr, input logic [3:0] strb, input int n,
                          input int nbits, input logic ed, input logic ee);
    int full;
    logic [7:0] idx;
    full = (nbits < 40) ? 0 : (nbits - 40) / 32;
    if (full > n) full = n;
    if ((addr >> 10) == 0) begin
      for (int k = 0; k < full; k++) begin
        idx = 8'(addr[9:2] + k);
        for (int l = 0; l < 4; l++)
          if (strb[l]) model_mem[idx][8*l +: 8] = wr_words[k][8*l +: 8];
      end
    end
    spi_xfer({4'h8, strb}, addr, nbits, -1, ed, ee);
  endtask

  task automatic rd_frame(input logic [31:0] addr, input int n, input int rst_bit,
                          input logic ed, input logic ee);
    logic [7:0] idx;
    for (int k = 0; k < n; k++) begin
      idx = 8'(addr[9:2] + k);
      exp_q.push_back(((addr >> 10) == 0) ? model_mem[idx] : 32'h0);
    end
    spi_xfer(8'h00, addr, 40 + 32 * n, rst_bit, ed, ee);
  endtask

  initial begin
    spi_rst  = 1'b1;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    model_clear();
    idle(4);
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    spi_rst = 1'b0;
    idle(6);

    // Single full-strobe write and readback
    wr_words[0] = 32'hDEADBEEF;
    wr_frame(32'h0, 4'hF, 1, 72, 1'b1, 1'b0);
    rd_frame(32'h0, 1, -1, 1'b1, 1'b0);

    // Partial byte strobes
    wr_words[0] = 32'h11111111;
    wr_frame(32'h20, 4'h1, 1, 72, 1'b1, 1'b0);
    wr_words[0] = 32'h22222222;
    wr_frame(32'h24, 4'h2, 1, 72, 1'b1, 1'b0);
    rd_frame(32'h20, 1, -1, 1'b1, 1'b0);
    rd_frame(32'h24, 1, -1, 1'b1, 1'b0);

    // Burst write / burst read
    for (int k = 0; k < 4; k++) wr_words[k] = 32'hBBFF1001 + 32'(k);
    wr_frame(32'h100, 4'hF, 4, 40 + 128, 1'b1, 1'b0);
    rd_frame(32'h100, 4, -1, 1'b1, 1'b0);

    // Aborted write mid-word keeps the old contents
    wr_words[0] = 32'hAAAABBBB;
    wr_frame(32'h40, 4'hF, 1, 72, 1'b1, 1'b0);
    wr_words[0] = 32'h12345678;
    wr_frame(32'h40, 4'hF, 1, 60, 1'b0, 1'b1);
    rd_frame(32'h40, 1, -1, 1'b1, 1'b0);

    // Out-of-range start address
    wr_words[0] = 32'h55555555;
    wr_frame(32'h1000, 4'hF, 1, 72, 1'b0, 1'b1);
    rd_frame(32'h1000, 1, -1, 1'b0, 1'b1);
    rd_frame(32'h0, 1, -1, 1'b1, 1'b0);

    // Reset in the middle of a burst read
    rd_frame(32'h100, 2, 52, 1'b0, 1'b0);
    rd_frame(32'h0, 1, -1, 1'b1, 1'b0);

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
